// File: rtl/bram_scan_seq.sv
// rtl/bram_scan_seq.sv - scan sequencer for the bit-serial BRAM ROI harness (di/stb/do chains)
// Define BRAM_SCAN_PARITY_EN to add the parity output (XOR of vec_out).
module bram_scan_seq #(
   parameter int DIN_N  = 160,
   parameter int DOUT_N = 160
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIN_N-1:0]  vec_in,
   output logic              busy,
   output logic              done,
   output logic [DOUT_N-1:0] vec_out,
   output logic              di,
   output logic              stb,
   input  logic              do_in
`ifdef BRAM_SCAN_PARITY_EN
   ,
   output logic              parity
`endif
);
   localparam int L  = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
   localparam int CW = $clog2(L + 1);
   localparam logic [CW-1:0] L_LAST = CW'(L - 1);
   localparam logic [CW-1:0] U_LAST = CW'(DOUT_N - 1);

   typedef enum logic [2:0] {IDLE, SHIFT, LOAD, RESHIFT, CAPT, UNLOAD, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [L-1:0]      vin_q, vin_d, vin_sh;
   logic [DOUT_N-1:0] shadow_q, shadow_d;
   logic [DOUT_N-1:0] vec_out_q, vec_out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              di_q, di_d;
   logic              stb_q, stb_d;
`ifdef BRAM_SCAN_PARITY_EN
   logic              parity_q, parity_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vin_d    = vin_q;
      shadow_d = shadow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               vin_d   = L'(vec_in);
            end
         end
         SHIFT, RESHIFT: begin
            if (cnt_q == L_LAST) begin
               state_d = (state_q == SHIFT) ? LOAD : CAPT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD: begin
            state_d = RESHIFT;
            cnt_d   = '0;
         end
         CAPT: begin
            state_d = UNLOAD;
            cnt_d   = '0;
         end
         UNLOAD: begin
            // First bit out of the chain is the MSB of the result
            shadow_d = {shadow_q[DOUT_N-2:0], do_in};
            if (cnt_q == U_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they line up with it once registered
      vin_sh    = vin_d >> (L_LAST - cnt_d);
      di_d      = ((state_d == SHIFT) || (state_d == RESHIFT)) && vin_sh[0];
      stb_d     = (state_d == LOAD) || (state_d == CAPT);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      vec_out_d = done_d ? shadow_d : vec_out_q;
`ifdef BRAM_SCAN_PARITY_EN
      parity_d  = done_d ? ^shadow_d : parity_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         vin_q     <= '0;
         shadow_q  <= '0;
         vec_out_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         di_q      <= 1'b0;
         stb_q     <= 1'b0;
`ifdef BRAM_SCAN_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vin_q     <= vin_d;
         shadow_q  <= shadow_d;
         vec_out_q <= vec_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         di_q      <= di_d;
         stb_q     <= stb_d;
`ifdef BRAM_SCAN_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign vec_out = vec_out_q;
   assign di      = di_q;
   assign stb     = stb_q;
`ifdef BRAM_SCAN_PARITY_EN
   assign parity  = parity_q;
`endif

endmodule

// File: tb/tb_bram_scan_seq.sv
// tb/tb_bram_scan_seq.sv - bench for bram_scan_seq with a behavioural harness and inverting ROI model
module tb_bram_scan_seq;
   localparam int N = 160;

   logic         clk = 1'b0;
   logic         rst, start, do_in, busy, done, di, stb;
   logic [N-1:0] vec_in, vec_out;
`ifdef BRAM_SCAN_PARITY_EN
   logic         parity;
`endif

   always #5 clk = ~clk;

   bram_scan_seq #(.DIN_N(N), .DOUT_N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .vec_in  (vec_in),
      .busy    (busy),
      .done    (done),
      .vec_out (vec_out),
      .di      (di),
      .stb     (stb),
      .do_in   (do_in)
`ifdef BRAM_SCAN_PARITY_EN
      ,
      .parity  (parity)
`endif
   );

   // Harness chains around an ROI whose dout is registered ~din
   logic [N-1:0] din_shr = '0, din_roi = '0, dout_roi = '0, dout_shr = '0;
   assign do_in = dout_shr[N-1];
   always @(posedge clk) begin
      if (stb) begin
         din_roi  <= din_shr;
         dout_shr <= dout_roi;
      end else begin
         din_shr  <= {din_shr[N-2:0], di};
         dout_shr <= {dout_shr[N-2:0], 1'b0};
      end
      dout_roi <= ~din_roi;
   end

   typedef struct {
      logic [N-1:0] exp;
      logic         par;
   } sb_t;

   typedef struct {
      logic [N-1:0] vin;
      logic [N-1:0] exp;
      logic         par;
   } vec_t;

   sb_t  q[$];
   sb_t  pend;
   bit   pend_valid = 0;
   int   tests = 0, fails = 0;
   int   cyc = 0, acc_cyc = 0, ndone = 0, done_c0 = 0, done_c1 = 0;
   int   stb_n = 0, stb_t1 = 0, stb_t2 = 0, stb_total = 0;
   bit   stb_prev = 0;

   task automatic check(input bit ok, input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         stb_n      = 0;
         pend_valid = 0;
         stb_prev   = 0;
      end else begin
         if (pend_valid) begin
            check(vec_out == pend.exp, "vec_out", vec_out, pend.exp);
`ifdef BRAM_SCAN_PARITY_EN
            check(parity == pend.par, "parity", N'(parity), N'(pend.par));
`endif
            pend_valid = 0;
         end
         if (stb) begin
            check(!stb_prev, "stb_consecutive", N'(stb_prev), N'(0));
            stb_total++;
            stb_n++;
            if (stb_n == 1) stb_t1 = cyc;
            else stb_t2 = cyc;
         end
         if (done) begin
            if (q.size() == 0) begin
               check(1'b0, "done_unexpected", N'(1), N'(0));
            end else begin
               pend       = q.pop_front();
               pend_valid = 1;
               check(cyc - acc_cyc == 483, "latency", N'(cyc - acc_cyc), N'(483));
               check(stb_n == 2, "stb_count", N'(stb_n), N'(2));
               check(stb_t2 - stb_t1 + 1 == 162, "stb_span", N'(stb_t2 - stb_t1 + 1), N'(162));
            end
            stb_n   = 0;
            ndone++;
            done_c0 = done_c1;
            done_c1 = cyc;
         end
         if (start && !busy) acc_cyc = cyc;
         stb_prev = stb;
      end
   end

   task automatic wait_ndone(input int target);
      int n = 0;
      while (ndone < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (ndone < target) check(1'b0, "done_timeout", N'(ndone), N'(target));
      #1;
   endtask

   task automatic run_one(input logic [N-1:0] vin, input logic [N-1:0] exp, input logic par);
      int b = ndone;
      q.push_back('{exp: exp, par: par});
      vec_in = vin;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      wait_ndone(b + 1);
      @(posedge clk); #1;
   endtask

   vec_t tbl[5];

   initial begin
      int b, s;
      logic [N-1:0] x, y;

      tbl[0] = '{vin: N'(1),             exp: {{159{1'b1}}, 1'b0},  par: 1'b1};
      tbl[1] = '{vin: {20{8'hA5}},       exp: {20{8'h5A}},          par: 1'b0};
      tbl[2] = '{vin: '0,                exp: '1,                   par: 1'b0};
      tbl[3] = '{vin: {5{32'hDEADBEEF}}, exp: {5{32'h21524110}},    par: 1'b0};
      tbl[4] = '{vin: N'(7),             exp: {{157{1'b1}}, 3'b000}, par: 1'b1};

      rst = 1'b1; start = 1'b0; vec_in = '0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check({busy, done, stb, di} == 4'b0, "reset_ctrl", N'({busy, done, stb, di}), N'(0));
         check(vec_out == '0, "reset_vec_out", vec_out, N'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({busy, done, stb, di} == 4'b0, "idle_ctrl", N'({busy, done, stb, di}), N'(0));
      end
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_one(tbl[i].vin, tbl[i].exp, tbl[i].par);

      // Second start mid-transaction must be dropped
      b = ndone;
      x = {10{16'h1234}};
      q.push_back('{exp: ~x, par: ^(~x)});
      vec_in = x; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      vec_in = '1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_ndone(b + 1);
      repeat (600) @(posedge clk);
      #1;
      check(ndone == b + 1, "ignored_start_done_count", N'(ndone), N'(b + 1));

      // Reset during RESHIFT aborts with no further strobes
      b = ndone;
      q.push_back('{exp: '0, par: 1'b0});
      vec_in = '1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (199) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check(busy == 1'b0, "abort_busy", N'(busy), N'(0));
      check(vec_out == '0, "abort_vec_out", vec_out, N'(0));
      check({stb, di} == 2'b0, "abort_stb_di", N'({stb, di}), N'(0));
      s = stb_total;
      repeat (400) @(posedge clk);
      #1;
      check(stb_total == s, "abort_no_stb", N'(stb_total), N'(s));
      check(ndone == b, "abort_no_done", N'(ndone), N'(b));
      run_one(tbl[1].vin, tbl[1].exp, tbl[1].par);

      // start held high across two back-to-back transactions
      b = ndone;
      x = {40{4'h9}};
      y = {5{32'h0F0F_3C3C}};
      q.push_back('{exp: ~x, par: ^(~x)});
      q.push_back('{exp: ~y, par: ^(~y)});
      vec_in = x; start = 1'b1;
      @(posedge clk); #1;
      vec_in = y;
      wait_ndone(b + 1);
      @(posedge clk); #1;
      start = 1'b0;
      wait_ndone(b + 2);
      check(done_c1 - done_c0 + 1 == 485, "b2b_done_span", N'(done_c1 - done_c0 + 1), N'(485));
      repeat (3) @(posedge clk);
      #1;
      check(q.size() == 0, "scoreboard_empty", N'(q.size()), N'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
